// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the game control unit: state codes shown on the
// display and the width of the per-move timeout timer.
package unidade_controle_pkg;

    localparam int TIMER_WIDTH = 16;

    typedef enum logic [3:0] {
        inicial       = 4'h0,
        preparacao    = 4'h1,
        espera_jogada = 4'h2,
        registra      = 4'h3,
        comparacao    = 4'h4,
        conta_acerto  = 4'h5,
        proximo       = 4'h6,
        incrementa    = 4'h7,
        fim_jogo      = 4'hA,
        esgotado      = 4'hE
    } estado_t;

endpackage

// File: rtl/unidade_controle_if.sv
// Control/status bundle between unidade_controle (slave side) and whoever
// drives it: the datapath status flags in, the datapath commands out.
interface unidade_controle_if;

    logic       iniciar;
    logic       fimE;
    logic       botaoIgualMemoria;
    logic       jogada_feita;
    logic       zeraA;
    logic       zeraE;
    logic       zeraR;
    logic       registraR;
    logic       contaE;
    logic       contaA;
    logic       pronto;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        output iniciar, fimE, botaoIgualMemoria, jogada_feita,
        input  zeraA, zeraE, zeraR, registraR, contaE, contaA,
               pronto, timeout, db_estado
    );

    modport slave (
        input  iniciar, fimE, botaoIgualMemoria, jogada_feita,
        output zeraA, zeraE, zeraR, registraR, contaE, contaA,
               pronto, timeout, db_estado
    );

endinterface

// File: rtl/unidade_controle_contador.sv
// Modulo-M up counter with synchronous clear; fim flags the last count (M-1).
module contador_m #(
    parameter int M = 16,
    parameter int N = 4
) (
    input  logic clock,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] valor;

    always_ff @(posedge clock) begin
        if (zera_s) begin
            valor <= '0;
        end else if (conta) begin
            valor <= (valor == N'(M - 1)) ? '0 : valor + N'(1);
        end
    end

    assign fim = (valor == N'(M - 1));

endmodule

// File: rtl/unidade_controle.sv
// Moore FSM sequencing one round of the memory game: wait for a press, register
// and compare it, count hits, advance the address, and time out idle players.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic               clock,
    input  logic               reset,
    unidade_controle_if.slave  bus
);

    estado_t estado;
    estado_t proximo_estado;
    logic    zera_tempo;
    logic    tempo_fim;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= inicial;
        end else begin
            estado <= proximo_estado;
        end
    end

    // The timer only runs while waiting for a move, so every wait starts at zero.
    assign zera_tempo = reset || (estado != espera_jogada);

    contador_m #(
        .M (TIMEOUT_CICLOS),
        .N (TIMER_WIDTH)
    ) u_timer (
        .clock  (clock),
        .zera_s (zera_tempo),
        .conta  (1'b1),
        .fim    (tempo_fim)
    );

    always_comb begin
        proximo_estado = estado;
        bus.zeraA      = 1'b0;
        bus.zeraE      = 1'b0;
        bus.zeraR      = 1'b0;
        bus.registraR  = 1'b0;
        bus.contaE     = 1'b0;
        bus.contaA     = 1'b0;
        bus.pronto     = 1'b0;
        bus.timeout    = 1'b0;

        case (estado)
            inicial: begin
                if (bus.iniciar) proximo_estado = preparacao;
            end
            preparacao: begin
                bus.zeraA      = 1'b1;
                bus.zeraE      = 1'b1;
                bus.zeraR      = 1'b1;
                proximo_estado = espera_jogada;
            end
            espera_jogada: begin
                // A press on the expiry cycle still counts as a valid move.
                if (bus.jogada_feita)   proximo_estado = registra;
                else if (tempo_fim)     proximo_estado = esgotado;
            end
            registra: begin
                bus.registraR  = 1'b1;
                proximo_estado = comparacao;
            end
            comparacao: begin
                proximo_estado = bus.botaoIgualMemoria ? conta_acerto : proximo;
            end
            conta_acerto: begin
                bus.contaA     = 1'b1;
                proximo_estado = proximo;
            end
            proximo: begin
                proximo_estado = bus.fimE ? fim_jogo : incrementa;
            end
            incrementa: begin
                bus.contaE     = 1'b1;
                proximo_estado = espera_jogada;
            end
            fim_jogo: begin
                bus.pronto = 1'b1;
                if (bus.iniciar) proximo_estado = preparacao;
            end
            esgotado: begin
                bus.pronto  = 1'b1;
                bus.timeout = 1'b1;
                if (bus.iniciar) proximo_estado = preparacao;
            end
            default: begin
                proximo_estado = inicial;
            end
        endcase
    end

    assign bus.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed and randomized games checked
// against an expected state trace built per move from the game rules.
module tb_unidade_controle;

    localparam int TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset;

    unidade_controle_if bus ();

    unidade_controle #(
        .TIMEOUT_CICLOS (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    // Expected {zeraA,zeraE,zeraR,registraR,contaE,contaA,pronto,timeout} per display code.
    function automatic logic [7:0] saidas_esperadas(input logic [3:0] codigo);
        case (codigo)
            4'h1:    return 8'b1110_0000;
            4'h3:    return 8'b0001_0000;
            4'h5:    return 8'b0000_0100;
            4'h7:    return 8'b0000_1000;
            4'hA:    return 8'b0000_0010;
            4'hE:    return 8'b0000_0011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic bit moeda();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_output(input logic [3:0] codigo, input string tag);
        logic [7:0] observado;
        logic [7:0] esperado;
        observado = {bus.zeraA, bus.zeraE, bus.zeraR, bus.registraR,
                     bus.contaE, bus.contaA, bus.pronto, bus.timeout};
        esperado  = saidas_esperadas(codigo);
        checks_total++;
        assert (bus.db_estado === codigo) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s db_estado: observed %h expected %h", tag, bus.db_estado, codigo);
        end
        checks_total++;
        assert (observado === esperado) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s outputs: observed %b expected %b", tag, observado, esperado);
        end
    endtask

    task automatic apply_stimulus(input bit ini, input bit jog, input bit igual, input bit fim);
        bus.iniciar           = ini;
        bus.jogada_feita      = jog;
        bus.botaoIgualMemoria = igual;
        bus.fimE              = fim;
    endtask

    // From inicial/fim_jogo/esgotado: request start, expect one clearing cycle, land in the wait.
    task automatic iniciar_jogo();
        apply_stimulus(1'b1, moeda(), moeda(), moeda());
        @(negedge clock);
        check_output(4'h1, "preparacao");
        apply_stimulus(moeda(), moeda(), moeda(), moeda());
        @(negedge clock);
    endtask

    // One move: idle for 'espera' cycles then press (espera >= TIMEOUT means never press).
    // Inputs that the current step must ignore are driven with random noise.
    task automatic run_jogada(input int espera, input bit acerto, input bit ultima);
        logic [3:0] seq[$];
        for (int k = 0; k < TIMEOUT; k++) begin
            check_output(4'h2, $sformatf("espera_ciclo_%0d", k));
            apply_stimulus(moeda(), k == espera, moeda(), moeda());
            @(negedge clock);
            if (k == espera) break;
        end
        if (espera >= TIMEOUT) begin
            check_output(4'hE, "esgotado");
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        seq = {4'h3, 4'h4};
        if (acerto) seq.push_back(4'h5);
        seq.push_back(4'h6);
        seq.push_back(ultima ? 4'hA : 4'h7);
        foreach (seq[i]) begin
            check_output(seq[i], $sformatf("jogada_estado_%0h", seq[i]));
            if (seq[i] == 4'hA) begin
                apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                apply_stimulus(moeda(), moeda(),
                               (seq[i] == 4'h4) ? acerto : moeda(),
                               (seq[i] == 4'h6) ? ultima : moeda());
                @(negedge clock);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_jogadas;
        int espera;

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check_output(4'h0, "reset_ciclo_1");
        @(negedge clock);
        check_output(4'h0, "reset_ciclo_2");
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, moeda(), moeda(), moeda());
            @(negedge clock);
            check_output(4'h0, "inicial_ocioso");
        end

        iniciar_jogo();
        run_jogada(2, 1'b1, 1'b0);
        run_jogada(0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            run_jogada($urandom_range(0, TIMEOUT - 2), moeda(), i == 13);
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, moeda(), moeda(), moeda());
            @(negedge clock);
            check_output(4'hA, "fim_jogo_parado");
        end

        iniciar_jogo();
        run_jogada(TIMEOUT, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, moeda(), moeda(), moeda());
            @(negedge clock);
            check_output(4'hE, "esgotado_parado");
        end

        iniciar_jogo();
        run_jogada(TIMEOUT - 1, 1'b1, 1'b0);

        check_output(4'h2, "antes_reset");
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        check_output(4'h3, "antes_reset");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check_output(4'h4, "antes_reset");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check_output(4'h5, "antes_reset");
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        check_output(4'h0, "reset_meio_jogo");
        @(negedge clock);
        check_output(4'h0, "reset_mantido");
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check_output(4'h0, "apos_reset");
        end

        for (int g = 0; g < 6; g++) begin
            iniciar_jogo();
            n_jogadas = $urandom_range(1, 6);
            for (int j = 0; j < n_jogadas; j++) begin
                espera = $urandom_range(0, TIMEOUT);
                run_jogada(espera, moeda(), j == n_jogadas - 1);
                if (espera >= TIMEOUT) break;
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 5000, meaning clock cycles allowed per jogada before timeout (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port iniciar, input, 1, start/restart request.
REQ-005 SHALL have ports fimE, botaoIgualMemoria, jogada_feita, input, 1 each: last address, match, and one-cycle press pulse from fluxo_dados.
REQ-006 SHALL have ports zeraA, zeraE, zeraR, registraR, contaE, contaA, output, 1 each, driving the same-named fluxo_dados inputs.
REQ-007 SHALL have ports pronto, timeout, output, 1 each: game finished / finished by timeout.
REQ-008 SHALL have port db_estado, output, 4, current state code for the 7-segment display.

Function
REQ-009 SHALL be a Moore FSM; every output is a function of the current state only.
REQ-010 SHALL use state codes: inicial=0x0, preparacao=0x1, espera_jogada=0x2, registra=0x3, comparacao=0x4, conta_acerto=0x5, proximo=0x6, incrementa=0x7, fim_jogo=0xA, esgotado=0xE; db_estado equals this code.
REQ-011 inicial: all outputs 0; iniciar=1 -> preparacao, else stay.
REQ-012 preparacao: zeraA=zeraE=zeraR=1 for exactly one cycle -> espera_jogada unconditionally.
REQ-013 espera_jogada: jogada_feita=1 -> registra; else timer at TIMEOUT_CICLOS-1 -> esgotado; else stay.
REQ-014 SHALL give jogada_feita priority when it coincides with timer expiry (-> registra).
REQ-015 registra: registraR=1 for one cycle -> comparacao.
REQ-016 comparacao: botaoIgualMemoria=1 -> conta_acerto; 0 -> proximo; comparison sampled in this state only.
REQ-017 conta_acerto: contaA=1 for one cycle -> proximo.
REQ-018 proximo: fimE=1 -> fim_jogo; else -> incrementa.
REQ-019 incrementa: contaE=1 for one cycle -> espera_jogada.
REQ-020 fim_jogo: pronto=1; esgotado: pronto=1 and timeout=1; in both, iniciar=1 -> preparacao, else stay.
REQ-021 SHALL ignore iniciar in all states other than inicial, fim_jogo, esgotado.
REQ-022 SHALL ignore jogada_feita outside espera_jogada (no queuing).
REQ-023 Timer: 16-bit, held at 0 in every state except espera_jogada, increments by 1 per cycle there, restarts at 0 on each entry; no wrap (expiry leaves the state first).
REQ-024 SHALL assert each pulse output (zera*, registraR, contaE, contaA) for exactly one cycle per state visit.

Reset
REQ-025 reset=1 SHALL force state inicial and timer 0 on the next rising edge, overriding all other inputs, from any state.
REQ-026 During and after reset all outputs SHALL be 0 and db_estado=0x0.
REQ-027 Reset mid-game SHALL NOT pulse zeraA/zeraE/zeraR; clearing the datapath occurs only via preparacao.

Structure
REQ-028 State codes and timer width (16) SHALL live in the shared project header/package, reused by the top level and benches.
REQ-029 The timeout timer SHALL be an instance of the existing contador_m (M=TIMEOUT_CICLOS, N=16), zeroed synchronously outside espera_jogada; no other sub-module.

Verification (bench uses TIMEOUT_CICLOS=8)
REQ-030 reset 2 cycles, then iniciar 1 cycle -> db_estado 0x0 -> 0x1 (zeraA/E/R=1 one cycle) -> 0x2.
REQ-031 In 0x2 pulse jogada_feita with botaoIgualMemoria=1, fimE=0 -> states 3,4,5,6,7,2; registraR, contaA, contaE each high exactly one cycle.
REQ-032 Same with botaoIgualMemoria=0 -> states 3,4,6,7,2; contaA never asserted.
REQ-033 16 jogadas, fimE=1 on the last -> reaches 0xA, pronto=1, timeout=0; iniciar -> 0x1.
REQ-034 No press in 0x2 -> exactly 8 cycles later 0xE, pronto=1, timeout=1; press on cycle 8 instead -> 0x3.
REQ-035 reset asserted in 0x5 -> next edge 0x0, all outputs 0, no zera pulse.
